// File: rtl/brcmp_pkg.sv
// rtl/brcmp_pkg.sv - shared types and helpers for the sequential branch comparator
//
// Purpose: branch funct3 encodings, comparator FSM states, chunk-count
// derivation and the funct3 -> taken decode used by branch_cmp_seq.
package brcmp_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } branch_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } brcmp_state_e;

  function automatic int nchunk_of(input int dwidth, input int chunk);
    return dwidth / chunk;
  endfunction

  // Reserved encodings (010/011) never take the branch.
  function automatic logic taken_of(input logic [2:0] func, input logic eq, input logic lt);
    logic t;
    case (func)
      OP_BEQ:           t = eq;
      OP_BNE:           t = !eq;
      OP_BLT, OP_BLTU:  t = lt;
      OP_BGE, OP_BGEU:  t = !lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one operand chunk
//
// Ports:
//   a, b : WIDTH-bit chunks of rs1 / rs2
//   eq   : a == b
//   lt   : a <  b (unsigned)
module chunk_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_cmp_seq.sv
// rtl/branch_cmp_seq.sv - multi-cycle chunked branch comparator with valid/ready
//
// Purpose: compares rs1/rs2 CHUNK bits per cycle, MSB chunk first, and
// decodes RISC-V branch funct3 into br_eq / br_lt / taken.
// Optional build macro BRCMP_EARLY_EXIT_EN: leave SCAN at the first differing
// chunk (latency 1..NCHUNK); otherwise always scan every chunk (latency NCHUNK).
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operation handshake (a, b, func)
//   a, b                 : DWIDTH-bit operands rs1, rs2
//   func                 : branch funct3
//   out_valid / out_ready: result handshake
//   br_eq, br_lt, taken  : registered result flags, stable while out_valid
module branch_cmp_seq
  import brcmp_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CHUNK  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [2:0]        func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              br_eq,
  output logic              br_lt,
  output logic              taken
);

  localparam int NCHUNK = nchunk_of(DWIDTH, CHUNK);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  brcmp_state_e      state, state_nxt;
  logic [DWIDTH-1:0] sh_a, sh_b;
  logic [2:0]        func_q;
  logic [CW-1:0]     cnt;
  logic              c_eq, c_lt;
  logic              accept, last, fin, res_eq, res_lt;
  logic              signed_op;
`ifndef BRCMP_EARLY_EXIT_EN
  logic              diff_seen, diff_lt;
`endif

  chunk_cmp #(.WIDTH(CHUNK)) u_chunk_cmp (
    .a  (sh_a[DWIDTH-1 -: CHUNK]),
    .b  (sh_b[DWIDTH-1 -: CHUNK]),
    .eq (c_eq),
    .lt (c_lt)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);
  // Only BLTU/BGEU are unsigned; the reserved 010/011 codes compare signed.
  assign signed_op = !(func[2] && func[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    res_eq    = 1'b0;
    res_lt    = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_SCAN;
      ST_SCAN: begin
`ifdef BRCMP_EARLY_EXIT_EN
        if (!c_eq) begin
          fin    = 1'b1;
          res_lt = c_lt;
        end else if (last) begin
          fin    = 1'b1;
          res_eq = 1'b1;
        end
`else
        // The first differing chunk is remembered in diff_seen/diff_lt;
        // the result is only published after the final chunk.
        if (last) begin
          fin    = 1'b1;
          res_eq = !diff_seen && c_eq;
          res_lt = diff_seen ? diff_lt : c_lt;
        end
`endif
        if (fin) state_nxt = ST_DONE;
      end
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      func_q    <= '0;
      cnt       <= '0;
      br_eq     <= 1'b0;
      br_lt     <= 1'b0;
      taken     <= 1'b0;
`ifndef BRCMP_EARLY_EXIT_EN
      diff_seen <= 1'b0;
      diff_lt   <= 1'b0;
`endif
    end else if (accept) begin
      // Flipping both sign bits turns a signed compare into an unsigned one.
      sh_a      <= a ^ {signed_op, {(DWIDTH-1){1'b0}}};
      sh_b      <= b ^ {signed_op, {(DWIDTH-1){1'b0}}};
      func_q    <= func;
      cnt       <= '0;
`ifndef BRCMP_EARLY_EXIT_EN
      diff_seen <= 1'b0;
      diff_lt   <= 1'b0;
`endif
    end else if (state == ST_SCAN) begin
`ifndef BRCMP_EARLY_EXIT_EN
      if (!diff_seen && !c_eq) begin
        diff_seen <= 1'b1;
        diff_lt   <= c_lt;
      end
`endif
      if (fin) begin
        br_eq <= res_eq;
        br_lt <= res_lt;
        taken <= taken_of(func_q, res_eq, res_lt);
      end else begin
        sh_a <= sh_a << CHUNK;
        sh_b <= sh_b << CHUNK;
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule
